// File: rtl/sisa_pkg.sv
// Shared definitions for the SISA program loader: memory geometry and the
// loader FSM state encoding.
package sisa_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int INSTR_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_e;

endpackage

// File: rtl/program_ram.sv
// Program storage: synchronous write, asynchronous read, synchronous
// active-low clear of every entry.
module program_ram
    import sisa_pkg::*;
#(
    parameter int DEPTH = PROG_DEPTH,
    parameter int WIDTH = INSTR_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Clear all entries on reset, otherwise write one entry when enabled.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a frame (length, L instruction bytes, checksum)
// over a valid/ready byte stream, writes it into program RAM and releases
// the CPU only once a frame has passed its checksum.
//
// Handshake: a byte moves only on a cycle where in_valid=1 and in_ready=1.
// in_ready is decoded from the registered state alone (LEN, DATA, CSUM) and
// never looks at in_valid, so the source may hold or drop in_valid freely.
module program_loader
    import sisa_pkg::*;
#(
    parameter int DEPTH = PROG_DEPTH,
    parameter int WIDTH = INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_instr,
    output logic                     cpu_hold,
    output logic                     load_done,
    output logic                     load_error,
    output loader_state_e            dbg_state
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    loader_state_e    state_q, state_d;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;

    logic xfer;
    logic start_go;
    logic len_ld;
    logic data_wr;

    assign xfer = in_valid && in_ready;

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        start_go = 1'b0;
        len_ld   = 1'b0;
        data_wr  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = ST_LEN;
                end
            end
            ST_LEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data != '0 && in_data <= DEPTH_W) begin
                        len_ld  = 1'b1;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_wr = 1'b1;
                    if (cnt_q == len_q - ONE_W) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == sum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: length, write pointer and running checksum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
        end else if (start_go) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else if (len_ld) begin
            len_q <= in_data;
        end else if (data_wr) begin
            cnt_q <= cnt_q + ONE_W;
            sum_q <= sum_q + in_data;
        end
    end

    program_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .clr_n (reset),
        .we    (data_wr && xfer),
        .waddr (cnt_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rd_instr)
    );

    assign cpu_hold   = (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign load_error = (state_q == ST_ERR);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good load, bad checksum, bad lengths,
// start/byte collision, mid-frame reset, backpressure and full-depth reload.
module tb_program_loader;
    import sisa_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic [3:0]    rd_addr = '0;
    logic [7:0]    rd_instr;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    loader_state_e dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] exp_q[$];

    program_loader #(.DEPTH(16), .WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_instr   (rd_instr),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame3(input logic [7:0] cs, input int gap);
        send_byte(8'h03, gap);
        send_byte(8'h85, gap);
        send_byte(8'h93, gap);
        send_byte(8'h04, gap);
        send_byte(cs, gap);
    endtask

    // Compare addresses 0..n-1 against the expected queue, in order.
    task automatic check_mem(input string tag, input int n);
        logic [7:0] e;
        for (int a = 0; a < n; a++) begin
            rd_addr = 4'(a);
            #1;
            if (exp_q.size() == 0) begin
                check({tag, "_qempty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check(tag, 32'(rd_instr), 32'(e));
            end
        end
    endtask

    task automatic push_good_image();
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h93);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h00);
    endtask

    initial begin
        // reset
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rd_addr = 4'd0;
        #1;
        check("rst_rd_instr", 32'(rd_instr), 32'h00);

        // good load
        pulse_start();
        check("len_ready_no_valid", 32'(in_ready), 32'd1);
        check("len_hold", 32'(cpu_hold), 32'd1);
        send_frame3(8'h1C, 0);
        check("good_done", 32'(load_done), 32'd1);
        check("good_hold", 32'(cpu_hold), 32'd0);
        check("good_err", 32'(load_error), 32'd0);
        check("good_ready", 32'(in_ready), 32'd0);
        rd_addr = 4'd1;
        #1;
        check("good_rd1", 32'(rd_instr), 32'h93);
        push_good_image();
        check_mem("good_mem", 4);

        // start coinciding with a byte in DONE: byte must not count as length
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h05;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("coll_state", 32'(dbg_state), 32'(ST_LEN));
        check("coll_done_clr", 32'(load_done), 32'd0);
        check("coll_hold", 32'(cpu_hold), 32'd1);

        // bad checksum
        send_frame3(8'h1D, 0);
        check("badcs_err", 32'(load_error), 32'd1);
        check("badcs_done", 32'(load_done), 32'd0);
        check("badcs_hold", 32'(cpu_hold), 32'd1);

        // bad lengths
        pulse_start();
        check("bl0_err_clr", 32'(load_error), 32'd0);
        send_byte(8'h00, 0);
        check("bl0_state", 32'(dbg_state), 32'(ST_ERR));
        tick();
        tick();
        check("bl0_ready", 32'(in_ready), 32'd0);
        pulse_start();
        send_byte(8'h11, 0);
        check("bl17_state", 32'(dbg_state), 32'(ST_ERR));
        check("bl17_err", 32'(load_error), 32'd1);
        tick();
        check("bl17_ready", 32'(in_ready), 32'd0);
        push_good_image();
        check_mem("bl_mem", 4);

        // reset mid-frame after two data bytes
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_hold", 32'(cpu_hold), 32'd1);
        for (int a = 0; a < 16; a++) exp_q.push_back(8'h00);
        check_mem("mid_mem", 16);

        // backpressure: two idle cycles before every byte
        pulse_start();
        send_frame3(8'h1C, 2);
        check("bp_done", 32'(load_done), 32'd1);
        check("bp_hold", 32'(cpu_hold), 32'd0);
        push_good_image();
        check_mem("bp_mem", 4);

        // full-depth reload
        pulse_start();
        check("full_hold_start", 32'(cpu_hold), 32'd1);
        send_byte(8'h10, 0);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 0);
            if (i == 7) check("full_hold_mid", 32'(cpu_hold), 32'd1);
        end
        check("full_csum_state", 32'(dbg_state), 32'(ST_CSUM));
        send_byte(8'h78, 0);
        check("full_done", 32'(load_done), 32'd1);
        check("full_hold_end", 32'(cpu_hold), 32'd0);
        rd_addr = 4'd15;
        #1;
        check("full_rd15", 32'(rd_instr), 32'h0F);
        for (int a = 0; a < 16; a++) exp_q.push_back(8'(a));
        check_mem("full_mem", 16);

        // report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
